// File: rtl/avalon_st_packet_arbiter.sv
// Packet-aware round-robin arbiter merging NUM_INPUTS Avalon-ST sources onto
// one registered Avalon-ST sink. The grant is held from the accepted SOP beat
// through the accepted EOP beat, so packets never interleave on the output.
//
// Handshake: a beat moves on any interface in the cycle where valid and ready
// are both high at posedge clk (ready latency 0). A source must hold its beat
// stable while valid is high and ready is low; the arbiter never drops a beat
// it has not accepted. The output register advances whenever it is empty or
// the sink is ready, and otherwise holds every field stable.
module avalon_st_packet_arbiter #(
    parameter int NUM_INPUTS  = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int EMPTY_WIDTH = 2,
    localparam int CH_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_INPUTS-1:0]             in_valid,
    output logic [NUM_INPUTS-1:0]             in_ready,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0]  in_data,
    input  logic [NUM_INPUTS-1:0]             in_sop,
    input  logic [NUM_INPUTS-1:0]             in_eop,
    input  logic [NUM_INPUTS*EMPTY_WIDTH-1:0] in_empty,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic                              out_sop,
    output logic                              out_eop,
    output logic [EMPTY_WIDTH-1:0]            out_empty,
    output logic [CH_W-1:0]                   out_channel,
    output logic                              proto_err
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                  state, state_nxt;
    logic [CH_W-1:0]         rr_ptr, rr_ptr_nxt;
    logic [CH_W-1:0]         lock_idx, lock_idx_nxt;
    logic [NUM_INPUTS-1:0]   rot_valid;
    logic [CH_W-1:0]         rr_off;
    logic [CH_W:0]           rr_sum;
    logic [CH_W-1:0]         rr_sel;
    logic                    rr_found;
    logic [CH_W-1:0]         sel;
    logic                    sel_ok;
    logic                    can_load;
    logic                    accept;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    sel_sop;
    logic                    sel_eop;
    logic [EMPTY_WIDTH-1:0]  sel_empty;

    // Index following x, wrapping NUM_INPUTS-1 back to 0.
    function automatic logic [CH_W-1:0] next_idx(input logic [CH_W-1:0] x);
        return (x == CH_W'(NUM_INPUTS - 1)) ? '0 : x + 1'b1;
    endfunction

    // Round-robin search: rotate valids so rr_ptr sits at bit 0, take the lowest set bit.
    always_comb begin
        rot_valid = NUM_INPUTS'({in_valid, in_valid} >> rr_ptr);
        rr_found  = 1'b0;
        rr_off    = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (!rr_found && rot_valid[k]) begin
                rr_found = 1'b1;
                rr_off   = CH_W'(k);
            end
        end
        rr_sum = {1'b0, rr_ptr} + {1'b0, rr_off};
        rr_sel = (rr_sum >= (CH_W+1)'(NUM_INPUTS)) ? CH_W'(rr_sum - (CH_W+1)'(NUM_INPUTS))
                                                   : rr_sum[CH_W-1:0];
    end

    // Grant selection, per-source ready and the selected beat's fields.
    always_comb begin
        can_load  = ~out_valid | out_ready;
        sel       = (state == LOCKED) ? lock_idx : rr_sel;
        sel_ok    = (state == LOCKED) ? 1'b1 : rr_found;
        in_ready  = '0;
        if (reset_n && can_load && sel_ok) begin
            in_ready[sel] = 1'b1;
        end
        accept    = |(in_valid & in_ready);
        sel_data  = in_data[sel*DATA_WIDTH +: DATA_WIDTH];
        sel_sop   = in_sop[sel];
        sel_eop   = in_eop[sel];
        sel_empty = in_empty[sel*EMPTY_WIDTH +: EMPTY_WIDTH];
    end

    // Next-state logic: lock on a non-EOP accept, release and advance the pointer on EOP.
    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        lock_idx_nxt = lock_idx;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (sel_eop) begin
                        rr_ptr_nxt = next_idx(sel);
                    end else begin
                        state_nxt    = LOCKED;
                        lock_idx_nxt = sel;
                    end
                end
            end
            LOCKED: begin
                if (accept && sel_eop) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = next_idx(lock_idx);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            lock_idx <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            lock_idx <= lock_idx_nxt;
        end
    end

    // Output register stage plus framing-error pulse; a held beat is dropped on reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_sop     <= 1'b0;
            out_eop     <= 1'b0;
            out_empty   <= '0;
            out_channel <= '0;
            proto_err   <= 1'b0;
        end else begin
            proto_err <= accept & ((state == IDLE) ? ~sel_sop : sel_sop);
            if (can_load) begin
                out_valid <= accept;
                if (accept) begin
                    out_data    <= sel_data;
                    out_sop     <= sel_sop;
                    out_eop     <= sel_eop;
                    out_empty   <= sel_empty;
                    out_channel <= sel;
                end
            end
        end
    end

endmodule

// File: tb/tb_avalon_st_packet_arbiter.sv
// Bench for avalon_st_packet_arbiter: directed vector table, hand-written
// backpressure and reset sequences, then randomized traffic checked against
// a cycle-level reference model and an expected-beat queue.
module tb_avalon_st_packet_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int EW = 2;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_sop;
    logic [N-1:0]    in_eop;
    logic [N*EW-1:0] in_empty;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic            out_sop;
    logic            out_eop;
    logic [EW-1:0]   out_empty;
    logic [1:0]      out_channel;
    logic            proto_err;

    avalon_st_packet_arbiter #(.NUM_INPUTS(N), .DATA_WIDTH(DW), .EMPTY_WIDTH(EW)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sop(in_sop), .in_eop(in_eop), .in_empty(in_empty),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty),
        .out_channel(out_channel), .proto_err(proto_err)
    );

    // Clock
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Per-source beat contents driven by step
    logic [DW-1:0] drv_data [N];
    logic [EW-1:0] drv_empty[N];
    logic [N-1:0]  rdy_seen;
    logic [N-1:0]  acc_seen;

    // Reference model: owner = -1 means no packet in progress
    int            m_owner = -1;
    int            m_ptr   = 0;
    int            m_g;
    logic [N-1:0]  m_rdy;
    logic          m_ov    = 1'b0;
    logic [DW-1:0] m_od    = '0;
    logic          m_os    = 1'b0;
    logic          m_oe    = 1'b0;
    logic [EW-1:0] m_oem   = '0;
    int            m_och   = 0;
    logic          m_perr  = 1'b0;
    logic [DW+1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // Which source is granted this cycle, from the round-robin and packet-lock rules.
    task automatic model_ready();
        m_g   = -1;
        m_rdy = '0;
        if (!reset_n) return;
        if (m_owner >= 0) begin
            m_g = m_owner;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (m_g < 0 && in_valid[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
            end
        end
        if (m_g >= 0 && (!m_ov || out_ready)) m_rdy[m_g] = 1'b1;
    endtask

    // Model update at the clock edge.
    task automatic model_clock();
        logic acc;
        if (!reset_n) begin
            m_owner = -1; m_ptr = 0; m_ov = 1'b0; m_od = '0; m_os = 1'b0;
            m_oe = 1'b0; m_oem = '0; m_och = 0; m_perr = 1'b0;
            exp_q.delete();
            return;
        end
        acc    = (m_g >= 0) && m_rdy[m_g] && in_valid[m_g];
        m_perr = acc && ((m_owner < 0) ? !in_sop[m_g] : in_sop[m_g]);
        if (!m_ov || out_ready) begin
            m_ov = acc;
            if (acc) begin
                m_od  = in_data[m_g*DW +: DW];
                m_os  = in_sop[m_g];
                m_oe  = in_eop[m_g];
                m_oem = in_empty[m_g*EW +: EW];
                m_och = m_g;
                exp_q.push_back({2'(m_g), m_od});
            end
        end
        if (acc) begin
            if (in_eop[m_g]) begin
                m_owner = -1;
                m_ptr   = (m_g + 1) % N;
            end else begin
                m_owner = m_g;
            end
        end
    endtask

    // Driver: one clock cycle of stimulus with model and scoreboard checks.
    task automatic step(input logic [N-1:0] v, input logic [N-1:0] s, input logic [N-1:0] e,
                        input logic ordy, input logic rn);
        logic [DW+1:0] want;
        @(negedge clk);
        reset_n   = rn;
        in_valid  = v;
        in_sop    = s;
        in_eop    = e;
        out_ready = ordy;
        for (int i = 0; i < N; i++) begin
            in_data[i*DW +: DW]  = drv_data[i];
            in_empty[i*EW +: EW] = drv_empty[i];
        end
        #1;
        model_ready();
        rdy_seen = in_ready;
        acc_seen = in_valid & in_ready;
        chk("in_ready", 64'(in_ready), 64'(m_rdy));
        if (m_ov && out_ready && rn) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow t=%0t actual=beat required=none", $time);
            end else begin
                want = exp_q.pop_front();
                if ({out_channel, out_data} !== want) begin
                    errors++;
                    $display("FAIL sb_beat t=%0t actual=%0h expected=%0h", $time,
                             {out_channel, out_data}, want);
                end
            end
        end
        @(posedge clk);
        model_clock();
        #1;
        chk("out_valid",   64'(out_valid),   64'(m_ov));
        chk("out_data",    64'(out_data),    64'(m_od));
        chk("out_sop",     64'(out_sop),     64'(m_os));
        chk("out_eop",     64'(out_eop),     64'(m_oe));
        chk("out_empty",   64'(out_empty),   64'(m_oem));
        chk("out_channel", 64'(out_channel), 64'(m_och));
        chk("proto_err",   64'(proto_err),   64'(m_perr));
    endtask

    typedef struct packed {
        logic [N-1:0] v;
        logic [N-1:0] s;
        logic [N-1:0] e;
        logic [N-1:0] exp_rdy;
        logic         exp_ov;
        logic [1:0]   exp_ch;
        logic         exp_perr;
    } vec_t;

    vec_t tbl[27];

    logic [DW-1:0] bp_beat[4];
    logic [N-1:0]  pres, r_sop, r_eop;
    int            rem[N];
    logic [DW-1:0] r_data[N];
    logic [EW-1:0] r_emp[N];
    int            bi;

    initial begin
        // Round robin 0..3 of 3-beat packets, lock while source 0 waits, singles, framing errors
        tbl[0]  = '{4'b1111, 4'b1111, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0};
        tbl[1]  = '{4'b1111, 4'b1110, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0};
        tbl[2]  = '{4'b1111, 4'b1110, 4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0};
        tbl[3]  = '{4'b1110, 4'b1110, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0};
        tbl[4]  = '{4'b1110, 4'b1100, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0};
        tbl[5]  = '{4'b1110, 4'b1100, 4'b0010, 4'b0010, 1'b1, 2'd1, 1'b0};
        tbl[6]  = '{4'b1100, 4'b1100, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0};
        tbl[7]  = '{4'b1100, 4'b1000, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0};
        tbl[8]  = '{4'b1100, 4'b1000, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b0};
        tbl[9]  = '{4'b1000, 4'b1000, 4'b0000, 4'b1000, 1'b1, 2'd3, 1'b0};
        tbl[10] = '{4'b1000, 4'b0000, 4'b0000, 4'b1000, 1'b1, 2'd3, 1'b0};
        tbl[11] = '{4'b1000, 4'b0000, 4'b1000, 4'b1000, 1'b1, 2'd3, 1'b0};
        tbl[12] = '{4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0};
        tbl[13] = '{4'b0101, 4'b0001, 4'b0001, 4'b0100, 1'b1, 2'd2, 1'b0};
        tbl[14] = '{4'b0101, 4'b0001, 4'b0001, 4'b0100, 1'b1, 2'd2, 1'b0};
        tbl[15] = '{4'b0101, 4'b0001, 4'b0001, 4'b0100, 1'b1, 2'd2, 1'b0};
        tbl[16] = '{4'b0101, 4'b0001, 4'b0101, 4'b0100, 1'b1, 2'd2, 1'b0};
        tbl[17] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0};
        tbl[18] = '{4'b1010, 4'b1010, 4'b1010, 4'b0010, 1'b1, 2'd1, 1'b0};
        tbl[19] = '{4'b1010, 4'b1010, 4'b1010, 4'b1000, 1'b1, 2'd3, 1'b0};
        tbl[20] = '{4'b1010, 4'b1010, 4'b1010, 4'b0010, 1'b1, 2'd1, 1'b0};
        tbl[21] = '{4'b1010, 4'b1010, 4'b1010, 4'b1000, 1'b1, 2'd3, 1'b0};
        tbl[22] = '{4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b1};
        tbl[23] = '{4'b0100, 4'b0000, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b0};
        tbl[24] = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0};
        tbl[25] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 1'b1, 2'd1, 1'b1};
        tbl[26] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};

        reset_n = 1'b0; in_valid = '0; in_sop = '0; in_eop = '0;
        in_data = '0; in_empty = '0; out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            drv_data[i]  = {8'(i), 24'h000000};
            drv_empty[i] = '0;
        end

        // Reset with every source requesting
        step(4'b1111, 4'b1111, 4'b0000, 1'b1, 1'b0);
        step(4'b1111, 4'b1111, 4'b0000, 1'b1, 1'b0);
        chk("rst_in_ready",  64'(rdy_seen),  64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_proto_err", 64'(proto_err), 64'(0));

        // Directed vector table
        for (int k = 0; k < 27; k++) begin
            for (int i = 0; i < N; i++) begin
                drv_data[i]  = {8'(i), 8'h5A, 16'(k)};
                drv_empty[i] = '0;
            end
            step(tbl[k].v, tbl[k].s, tbl[k].e, 1'b1, 1'b1);
            chk("tbl_ready",     64'(rdy_seen),  64'(tbl[k].exp_rdy));
            chk("tbl_out_valid", 64'(out_valid), 64'(tbl[k].exp_ov));
            if (tbl[k].exp_ov) chk("tbl_channel", 64'(out_channel), 64'(tbl[k].exp_ch));
            chk("tbl_proto_err", 64'(proto_err), 64'(tbl[k].exp_perr));
        end

        // Backpressure: out_ready 1,0,0,1,... during a 4-beat packet from source 0
        for (int k = 0; k < 4; k++) bp_beat[k] = 32'hCAFE_0000 + 32'(k);
        bi = 0;
        for (int c = 0; c < 7; c++) begin
            logic ordy;
            ordy = (c == 1 || c == 2) ? 1'b0 : 1'b1;
            if (bi < 4) begin
                drv_data[0]  = bp_beat[bi];
                drv_empty[0] = (bi == 3) ? 2'd3 : 2'd0;
                step(4'b0001, (bi == 0) ? 4'b0001 : 4'b0000, (bi == 3) ? 4'b0001 : 4'b0000,
                     ordy, 1'b1);
            end else begin
                step(4'b0000, 4'b0000, 4'b0000, ordy, 1'b1);
            end
            if (acc_seen[0]) bi++;
            if (c == 1 || c == 2) begin
                chk("bp_stall_ready", 64'(rdy_seen),  64'(0));
                chk("bp_stall_valid", 64'(out_valid), 64'(1));
                chk("bp_stall_data",  64'(out_data),  64'(bp_beat[0]));
            end
            if (c == 5) begin
                chk("bp_eop_data",  64'(out_data),  64'(bp_beat[3]));
                chk("bp_eop_flag",  64'(out_eop),   64'(1));
                chk("bp_eop_empty", 64'(out_empty), 64'(3));
            end
        end
        chk("bp_beats_taken", 64'(bi), 64'(4));
        drv_empty[0] = '0;

        // Reset in the middle of a packet from source 1
        step(4'b0010, 4'b0010, 4'b0000, 1'b1, 1'b1);
        chk("mid_lock_channel", 64'(out_channel), 64'(1));
        step(4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b0);
        chk("mid_rst_ready", 64'(rdy_seen),  64'(0));
        chk("mid_rst_valid", 64'(out_valid), 64'(0));
        step(4'b1111, 4'b1111, 4'b1111, 1'b1, 1'b1);
        chk("post_rst_grant",   64'(rdy_seen),    64'(4'b0001));
        chk("post_rst_channel", 64'(out_channel), 64'(0));
        step(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1);

        // Randomized traffic: sources hold each beat until accepted
        pres = '0; r_sop = '0; r_eop = '0;
        for (int i = 0; i < N; i++) begin
            rem[i] = 0; r_data[i] = '0; r_emp[i] = '0;
        end
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pres[i] && $urandom_range(0, 1) == 1) begin
                    if (rem[i] == 0) begin
                        rem[i]   = $urandom_range(1, 4);
                        r_sop[i] = 1'b1;
                    end else begin
                        r_sop[i] = 1'b0;
                    end
                    if ($urandom_range(0, 19) == 0) r_sop[i] = ~r_sop[i];
                    r_eop[i]  = (rem[i] == 1);
                    r_data[i] = $urandom;
                    r_emp[i]  = r_eop[i] ? 2'($urandom_range(0, 3)) : 2'd0;
                    pres[i]   = 1'b1;
                end
                drv_data[i]  = r_data[i];
                drv_empty[i] = r_emp[i];
            end
            step(pres, r_sop, r_eop, $urandom_range(0, 3) != 0, $urandom_range(0, 199) != 0);
            for (int i = 0; i < N; i++) begin
                if (acc_seen[i]) begin
                    pres[i] = 1'b0;
                    rem[i]  = rem[i] - 1;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
